// File: rtl/zipdma_mcheck.sv
// rtl/zipdma_mcheck.sv - per-channel LFSR pattern generator/checker for DMA copy verification
// Optional build macro ZIPDMA_MCHECK_STALL_EN adds pseudo-random stalls on the data port.
module zipdma_mcheck #(
   parameter int ADDRESS_WIDTH = 30,
   parameter int BUS_WIDTH     = 64,
   parameter int NCH           = 4,
   parameter int LGCOUNT       = 16
) (
   input  logic                                               i_clk,
   input  logic                                               i_reset,
   input  logic                                               i_wb_cyc,
   input  logic                                               i_wb_stb,
   input  logic                                               i_wb_we,
   input  logic [ADDRESS_WIDTH-$clog2(BUS_WIDTH/8)-1:0]       i_wb_addr,
   input  logic [BUS_WIDTH-1:0]                               i_wb_data,
   input  logic [BUS_WIDTH/8-1:0]                             i_wb_sel,
   output logic                                               o_wb_stall,
   output logic                                               o_wb_ack,
   output logic [BUS_WIDTH-1:0]                               o_wb_data,
   output logic                                               o_wb_err,
   input  logic                                               i_st_cyc,
   input  logic                                               i_st_stb,
   input  logic                                               i_st_we,
   input  logic [((NCH > 1) ? $clog2(NCH) : 1)+1:0]           i_st_addr,
   input  logic [31:0]                                        i_st_data,
   input  logic [3:0]                                         i_st_sel,
   output logic                                               o_st_stall,
   output logic                                               o_st_ack,
   output logic [31:0]                                        o_st_data,
   output logic                                               o_st_err
);
   localparam int DW = BUS_WIDTH;
   localparam int NB = BUS_WIDTH / 8;
   localparam int AW = ADDRESS_WIDTH - $clog2(NB);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int PW = $clog2(NB + 1);

   logic [DW-1:0]      rd_lfsr_q  [NCH];
   logic [DW-1:0]      rd_lfsr_d  [NCH];
   logic [DW-1:0]      wr_lfsr_q  [NCH];
   logic [DW-1:0]      wr_lfsr_d  [NCH];
   logic [LGCOUNT-1:0] rdcnt_q    [NCH];
   logic [LGCOUNT-1:0] rdcnt_d    [NCH];
   logic [LGCOUNT-1:0] wrcnt_q    [NCH];
   logic [LGCOUNT-1:0] wrcnt_d    [NCH];
   logic               err_q      [NCH];
   logic               err_d      [NCH];
   logic [6:0]         cap_mask_q [NCH];
   logic [6:0]         cap_mask_d [NCH];
   logic [23:0]        cap_addr_q [NCH];
   logic [23:0]        cap_addr_d [NCH];

   logic               wb_ack_q, wb_ack_d;
   logic [DW-1:0]      wb_data_q, wb_data_d;
   logic               st_ack_q, st_ack_d;
   logic [31:0]        st_data_q, st_data_d;

   logic               wb_accept;
   logic               wb_active;
   logic [CW-1:0]      wb_ch;
   logic [CW-1:0]      st_ch;
   logic [1:0]         st_reg;
   logic               seed_wr;
   logic [31:0]        seed_val;
   logic [NB-1:0]      mism;
   logic [PW-1:0]      sel_cnt;
   logic               unused_inputs;

   function automatic logic [DW-1:0] lfsr_step(input logic [DW-1:0] s);
      return {s[DW-2:0], s[DW-1] ^ s[DW-2]};
   endfunction

   function automatic logic [LGCOUNT-1:0] sat_add(input logic [LGCOUNT-1:0] a,
                                                  input logic [PW-1:0] n);
      logic [LGCOUNT:0] s;
      s = {1'b0, a} + {{(LGCOUNT+1-PW){1'b0}}, n};
      return s[LGCOUNT] ? {LGCOUNT{1'b1}} : s[LGCOUNT-1:0];
   endfunction

`ifdef ZIPDMA_MCHECK_STALL_EN
   logic [15:0] stall_lfsr_q, stall_lfsr_d;

   always_comb begin
      stall_lfsr_d = {stall_lfsr_q[14:0],
                      stall_lfsr_q[15] ^ stall_lfsr_q[13] ^ stall_lfsr_q[12] ^ stall_lfsr_q[10]};
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) stall_lfsr_q <= 16'hACE1;
      else         stall_lfsr_q <= stall_lfsr_d;
   end

   assign o_wb_stall = stall_lfsr_q[0] & i_wb_cyc;
`else
   assign o_wb_stall = 1'b0;
`endif

   assign o_wb_err   = 1'b0;
   assign o_st_stall = 1'b0;
   assign o_st_err   = 1'b0;
   assign o_wb_ack   = wb_ack_q;
   assign o_wb_data  = wb_data_q;
   assign o_st_ack   = st_ack_q;
   assign o_st_data  = st_data_q;

   assign unused_inputs = ^{i_st_cyc, i_wb_cyc, i_wb_addr};

   assign wb_accept = i_wb_stb && !o_wb_stall;
   assign wb_active = wb_accept && (i_wb_sel != '0);
   assign wb_ch     = (NCH == 1) ? '0 : i_wb_addr[AW-1 -: CW];
   assign st_ch     = (NCH == 1) ? '0 : i_st_addr[CW+1:2];
   assign st_reg    = i_st_addr[1:0];
   assign seed_wr   = i_st_stb && i_st_we && (st_reg == 2'd0) && (i_st_sel != 4'h0);
   assign seed_val  = i_st_data & {{8{i_st_sel[3]}}, {8{i_st_sel[2]}},
                                   {8{i_st_sel[1]}}, {8{i_st_sel[0]}}};

   always_comb begin
      mism    = '0;
      sel_cnt = '0;
      for (int b = 0; b < NB; b++) begin
         mism[b] = i_wb_sel[b] && (i_wb_data[8*b +: 8] != wr_lfsr_q[wb_ch][8*b +: 8]);
         sel_cnt = sel_cnt + PW'(i_wb_sel[b]);
      end
   end

   always_comb begin
      wb_ack_d  = wb_accept;
      wb_data_d = (wb_accept && !i_wb_we) ? rd_lfsr_q[wb_ch] : wb_data_q;
      st_ack_d  = i_st_stb;
      st_data_d = st_data_q;
      if (i_st_stb) begin
         case (st_reg)
            2'd0:    st_data_d = rd_lfsr_q[st_ch][DW-1 -: 32];
            2'd1:    st_data_d = 32'(rdcnt_q[st_ch]);
            2'd2:    st_data_d = 32'(wrcnt_q[st_ch]);
            default: st_data_d = {err_q[st_ch], cap_mask_q[st_ch], cap_addr_q[st_ch]};
         endcase
      end

      for (int c = 0; c < NCH; c++) begin
         rd_lfsr_d[c]  = rd_lfsr_q[c];
         wr_lfsr_d[c]  = wr_lfsr_q[c];
         rdcnt_d[c]    = rdcnt_q[c];
         wrcnt_d[c]    = wrcnt_q[c];
         err_d[c]      = err_q[c];
         cap_mask_d[c] = cap_mask_q[c];
         cap_addr_d[c] = cap_addr_q[c];
         // A seed write to this channel suppresses any coincident beat on it.
         if (seed_wr && (st_ch == CW'(c))) begin
            rd_lfsr_d[c]  = DW'(seed_val) << (DW - 32);
            wr_lfsr_d[c]  = DW'(seed_val) << (DW - 32);
            rdcnt_d[c]    = '0;
            wrcnt_d[c]    = '0;
            err_d[c]      = 1'b0;
            cap_mask_d[c] = '0;
            cap_addr_d[c] = '0;
         end else if (wb_active && (wb_ch == CW'(c))) begin
            if (i_wb_we) begin
               wr_lfsr_d[c] = lfsr_step(wr_lfsr_q[c]);
               wrcnt_d[c]   = sat_add(wrcnt_q[c], sel_cnt);
               if (mism != '0) begin
                  err_d[c] = 1'b1;
                  if (!err_q[c]) begin
                     cap_mask_d[c] = 7'(mism);
                     cap_addr_d[c] = 24'(i_wb_addr);
                  end
               end
            end else begin
               rd_lfsr_d[c] = lfsr_step(rd_lfsr_q[c]);
               rdcnt_d[c]   = sat_add(rdcnt_q[c], sel_cnt);
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int c = 0; c < NCH; c++) begin
            rd_lfsr_q[c]  <= '0;
            wr_lfsr_q[c]  <= '0;
            rdcnt_q[c]    <= '0;
            wrcnt_q[c]    <= '0;
            err_q[c]      <= 1'b0;
            cap_mask_q[c] <= '0;
            cap_addr_q[c] <= '0;
         end
         wb_ack_q  <= 1'b0;
         wb_data_q <= '0;
         st_ack_q  <= 1'b0;
         st_data_q <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            rd_lfsr_q[c]  <= rd_lfsr_d[c];
            wr_lfsr_q[c]  <= wr_lfsr_d[c];
            rdcnt_q[c]    <= rdcnt_d[c];
            wrcnt_q[c]    <= wrcnt_d[c];
            err_q[c]      <= err_d[c];
            cap_mask_q[c] <= cap_mask_d[c];
            cap_addr_q[c] <= cap_addr_d[c];
         end
         wb_ack_q  <= wb_ack_d;
         wb_data_q <= wb_data_d;
         st_ack_q  <= st_ack_d;
         st_data_q <= st_data_d;
      end
   end
endmodule

// File: doc/zipdma_mcheck.md
ZIPDMA_MCHECK -- requirements
Module: zipdma_mcheck

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 30, byte-address width of the data port.
REQ-002 SHALL have parameter BUS_WIDTH, default 64, data-port width in bits (power of two, >=32); AW = ADDRESS_WIDTH-log2(BUS_WIDTH/8).
REQ-003 SHALL have parameter NCH, default 4, number of independent pattern channels (power of two, 1..16); CW = max(1,log2(NCH)).
REQ-004 SHALL have parameter LGCOUNT, default 16, byte-counter width.
REQ-005 i_clk  in  1  clock; i_reset  in  1  reset, synchronous, active-high.
REQ-006 i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  data-port Wishbone controls.
REQ-007 i_wb_addr  in  AW  word address; channel = i_wb_addr[AW-1 -: CW].
REQ-008 i_wb_data  in  BUS_WIDTH  write data; i_wb_sel  in  BUS_WIDTH/8  byte enables.
REQ-009 o_wb_stall  out  1; o_wb_ack  out  1; o_wb_data  out  BUS_WIDTH; o_wb_err  out  1  (constant 0).
REQ-010 i_st_cyc, i_st_stb, i_st_we  in  1 each; i_st_addr  in  CW+2  register index; i_st_data  in  32; i_st_sel  in  4.
REQ-011 o_st_stall  out  1 (constant 0); o_st_ack  out  1; o_st_data  out  32; o_st_err  out  1 (constant 0).

Function
REQ-012 Each channel SHALL hold separate BUS_WIDTH-bit read and write LFSRs; step = {s[DW-2:0], s[DW-1]^s[DW-2]}.
REQ-013 Beat accepted when i_wb_stb && !o_wb_stall; o_wb_ack SHALL assert exactly one cycle after each accepted beat, regardless of i_wb_sel.
REQ-014 Accepted read, sel!=0: o_wb_data SHALL be the channel read-LFSR value at accept, registered, valid with o_wb_ack; read LFSR then steps once.
REQ-015 Accepted write, sel!=0: each enabled byte SHALL be compared against the channel write-LFSR byte; write LFSR then steps once.
REQ-016 Any byte mismatch SHALL set the channel sticky ERR flag; on the first mismatch since seed, SHALL capture the beat word address (low 24 bits) and the mismatching byte mask; later mismatches do not overwrite.
REQ-017 Per channel, RDCNT/WRCNT SHALL add popcount(i_wb_sel) per accepted read/write beat, saturating at 2^LGCOUNT-1.
REQ-018 Beats with sel==0 SHALL be acked but SHALL NOT step LFSRs, count, or compare.
REQ-019 Status register index {ch,r}: r=0 SEED, r=1 RDCNT, r=2 WRCNT, r=3 ERRSTAT = {ERR, mask[6:0], addr[23:0]}; mask bits beyond 7 are dropped.
REQ-020 Status write to SEED with i_st_sel!=0: both channel LFSRs SHALL load {seed bytes selected by i_st_sel, zeros} in the top 32 bits and zero elsewhere; counters, ERR and capture SHALL clear; writes to other indexes are ignored.
REQ-021 o_st_ack SHALL assert one cycle after each i_st_stb; o_st_data SHALL be the addressed register at that time (SEED reads the top 32 bits of the read LFSR).
REQ-022 Seed write and data beat to the same channel in the same cycle: seed wins, beat is acked but neither stepped, counted nor compared.
REQ-023 All-zero seed SHALL leave the LFSRs at zero (legal, no special handling).
REQ-024 Channels SHALL be fully independent; DMA copy from channel A to channel B passes iff both hold the same seed.

Reset
REQ-025 On i_reset all LFSRs, counters, ERR, capture registers, o_wb_ack, o_st_ack, o_wb_data and o_st_data SHALL be zero the following cycle.
REQ-026 Reset mid-burst SHALL drop any pending ack; beats presented during reset are not acked.

Configuration
REQ-027 With ZIPDMA_MCHECK_STALL_EN defined, o_wb_stall SHALL be bit 0 of a free-running 16-bit LFSR (reset 16'hACE1, stepped every cycle) ANDed with i_wb_cyc; without it, o_wb_stall SHALL be constant 0.

Verification
REQ-028 Seed ch0 = 32'h1234_5678, read 4 beats sel=all -> first o_wb_data = 64'h1234_5678_0000_0000, RDCNT0 = 32, ERR0 = 0.
REQ-029 Seed ch1 and ch2 = 32'hDEAD_BEEF, copy 16 beats ch1->ch2 -> WRCNT2 = 128, ERRSTAT2 bit31 = 0.
REQ-030 Same copy with beat 5 byte 2 XOR 8'h01 -> ERRSTAT2 = {1, 7'h04, address of beat 5}, remaining beats still compared, capture unchanged.
REQ-031 Seed write to ch0 coincident with ch0 read beat -> ack asserted, RDCNT0 = 0, next read returns seed pattern.
REQ-032 Force RDCNT near 2^LGCOUNT-1, read 2 more beats -> RDCNT stays 2^LGCOUNT-1.
REQ-033 With ZIPDMA_MCHECK_STALL_EN, 64-beat burst under random stalls -> exactly 64 acks, counts and compare identical to unstalled run.
